// File: rtl/key_mode_controller_pkg.sv
// ============================================================================
// key_mode_controller_pkg : mode encodings and KEY[1] state type
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package key_mode_controller_pkg;

  localparam logic [1:0] MODE_ARITH   = 2'd0;
  localparam logic [1:0] MODE_LOGIC   = 2'd1;
  localparam logic [1:0] MODE_COMPARE = 2'd2;
  localparam logic [1:0] MODE_MAGIC   = 2'd3;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } key1_state_t;

endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// key_debouncer : 2-flop sync, debounce counter and registered press pulse
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_level_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;

  assign w_differ = (r_sync[1] != r_level);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_key_n};
      r_level_q <= r_level;
      // Pulse one cycle after the debounced level falls.
      r_press   <= r_level_q & ~r_level;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

`default_nettype wire

// File: rtl/key_mode_controller.sv
// ============================================================================
// key_mode_controller : debounced KEY inputs driving the calculator MODE select
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module key_mode_controller
  import key_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  output logic [1:0] MODE,
  output logic [1:0] KEY_PRESS,
  output logic       MODE_CHANGED
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [1:0]        w_level;
  logic [1:0]        w_press;
  logic              w_unused_level0;
  key1_state_t       r_state;
  key1_state_t       w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_short;
  logic              w_long;
  logic [1:0]        r_mode;
  logic [1:0]        w_mode_nxt;
  logic              r_mode_changed;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_key_n (KEY[gi]),
        .o_level (w_level[gi]),
        .o_press (w_press[gi])
      );
    end
  endgenerate

  // KEY[0] acts only on its press pulse; its level is not needed here.
  assign w_unused_level0 = w_level[0];

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_short     = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      RELEASED: begin
        if (!w_level[1]) begin
          w_state_nxt = PRESSED;
          w_hold_nxt  = '0;
        end
      end
      PRESSED: begin
        // A release on the terminal count still counts as a short press.
        if (w_level[1]) begin
          w_short     = 1'b1;
          w_state_nxt = RELEASED;
        end else if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
          w_long      = 1'b1;
          w_state_nxt = HELD;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      HELD: begin
        if (w_level[1]) begin
          w_state_nxt = RELEASED;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_long) begin
      w_mode_nxt = MODE_ARITH;
    end else if (w_press[0] && !w_short) begin
      w_mode_nxt = r_mode + 2'd1;
    end else if (w_short && !w_press[0]) begin
      w_mode_nxt = r_mode - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state        <= RELEASED;
      r_hold         <= '0;
      r_mode         <= MODE_ARITH;
      r_mode_changed <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold         <= w_hold_nxt;
      r_mode         <= w_mode_nxt;
      r_mode_changed <= (w_mode_nxt != r_mode);
    end
  end

  assign MODE         = r_mode;
  assign KEY_PRESS    = w_press;
  assign MODE_CHANGED = r_mode_changed;

endmodule

`default_nettype wire

// File: tb/tb_key_mode_controller.sv
// ============================================================================
// tb_key_mode_controller : scoreboard bench with a timing-rule reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_mode_controller;

  localparam int D    = 4;
  localparam int H    = 16;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic [1:0] mode;
  logic [1:0] kp;
  logic       mc;

  always #5 clk = ~clk;

  key_mode_controller #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .KEY          (key),
    .MODE         (mode),
    .KEY_PRESS    (kp),
    .MODE_CHANGED (mc)
  );

  typedef struct {
    int         cyc;
    logic [1:0] kp;
    logic       mc;
    logic [1:0] mode;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         mon_cyc = 0;
  logic [1:0] exp_mode [0:MAXC-1];

  // Reference model state: raw samples per edge, debounced levels, events.
  logic [1:0] raw_hist [0:MAXC-1];
  int         n_edge   = 0;
  int         last_rst = 0;
  logic [1:0] m_lvl    = 2'b11;
  logic [1:0] m_kp     = 2'b00;
  logic [1:0] m_fell   = 2'b00;
  logic [1:0] m_rose   = 2'b00;
  logic [1:0] m_mode   = 2'd0;
  bit         pending  = 1'b0;
  int         fall_t   = 0;

  function automatic logic sample(input int j, input int k);
    if (j <= last_rst) return 1'b1;
    return raw_hist[j][k];
  endfunction

  // A debounced level flips once the last D synchronised samples
  // (raw at edges n-2 .. n-1-D) all differ from it.
  task automatic model_edge(input logic r);
    int         n;
    logic [1:0] nl;
    logic [1:0] kp_new;
    logic [1:0] nm;
    bit         flip;
    bit         inc;
    bit         dec;
    bit         lng;
    exp_t       e;
    n = n_edge;
    if (!r) begin
      last_rst = n;
      m_lvl = 2'b11; m_kp = 2'b00; m_fell = 2'b00; m_rose = 2'b00;
      m_mode = 2'd0; pending = 1'b0;
      exp_mode[n] = 2'd0;
      return;
    end
    nl = m_lvl;
    for (int k = 0; k < 2; k++) begin
      flip = 1'b1;
      for (int j = n - 1 - D; j <= n - 2; j++)
        if (sample(j, k) == m_lvl[k]) flip = 1'b0;
      if (flip) nl[k] = ~m_lvl[k];
    end
    kp_new = m_fell;
    inc = m_kp[0];
    dec = 1'b0;
    lng = 1'b0;
    if (m_rose[1] && pending) begin
      dec = 1'b1; pending = 1'b0;
    end else if (pending && (n - 1 == fall_t + H)) begin
      lng = 1'b1; pending = 1'b0;
    end
    if (lng)             nm = 2'd0;
    else if (inc && !dec) nm = 2'((int'(m_mode) + 1) % 4);
    else if (dec && !inc) nm = 2'((int'(m_mode) + 3) % 4);
    else                  nm = m_mode;
    m_fell = m_lvl & ~nl;
    m_rose = ~m_lvl & nl;
    if (m_fell[1]) begin
      pending = 1'b1;
      fall_t  = n;
    end
    if (kp_new != 2'b00 || nm != m_mode) begin
      e.cyc = n; e.kp = kp_new; e.mc = (nm != m_mode); e.mode = nm;
      q.push_back(e);
    end
    m_lvl = nl;
    m_kp = kp_new;
    m_mode = nm;
    exp_mode[n] = nm;
  endtask

  task automatic cycle(input logic [1:0] k, input logic r);
    key   = k;
    rst_n = r;
    n_edge++;
    raw_hist[n_edge] = k;
    model_edge(r);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] k, input logic r, input int cnt);
    for (int i = 0; i < cnt; i++) cycle(k, r);
  endtask

  always @(posedge clk) mon_cyc++;

  // Monitor: pops an expected event whenever the DUT shows one.
  always @(negedge clk) begin
    exp_t e;
    if (mon_cyc > 0 && mon_cyc < MAXC) begin
      checks++;
      if (mode !== exp_mode[mon_cyc]) begin
        errors++;
        $display("FAIL mode cyc=%0d: got %0d expected %0d", mon_cyc, mode, exp_mode[mon_cyc]);
      end
      if (kp !== 2'b00 || mc !== 1'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d: got kp=%b mc=%b, expected none", mon_cyc, kp, mc);
        end else begin
          e = q.pop_front();
          if (e.cyc != mon_cyc || e.kp !== kp || e.mc !== mc || e.mode !== mode) begin
            errors++;
            $display("FAIL event cyc=%0d: got kp=%b mc=%b mode=%0d, expected cyc=%0d kp=%b mc=%b mode=%0d",
                     mon_cyc, kp, mc, mode, e.cyc, e.kp, e.mc, e.mode);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= mon_cyc) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL missing_event cyc=%0d: got none, expected kp=%b mc=%b mode=%0d",
                 e.cyc, e.kp, e.mc, e.mode);
      end
    end
  end

  initial begin
    logic [1:0] rk;
    key   = 2'b11;
    rst_n = 1'b0;
    hold(2'b11, 1'b0, 3);
    hold(2'b11, 1'b1, 50);
    // Four clean KEY[0] presses: MODE 1, 2, 3, 0.
    for (int p = 0; p < 4; p++) begin
      hold(2'b10, 1'b1, 10);
      hold(2'b11, 1'b1, 10);
    end
    // Bounce in runs of 2 cycles, shorter than the debounce window.
    for (int i = 0; i < 20; i++) cycle(((i / 2) % 2 == 0) ? 2'b10 : 2'b11, 1'b1);
    hold(2'b11, 1'b1, 12);
    // Short KEY[1] press from MODE 0 -> 3, then again -> 2.
    hold(2'b01, 1'b1, 8);
    hold(2'b11, 1'b1, 12);
    hold(2'b01, 1'b1, 8);
    hold(2'b11, 1'b1, 12);
    // Long KEY[1] hold from MODE 2 -> 0, release without change.
    hold(2'b01, 1'b1, 40);
    hold(2'b11, 1'b1, 12);
    // KEY[0] press aligned with the KEY[1] short-press release event.
    hold(2'b01, 1'b1, 9);
    cycle(2'b00, 1'b1);
    hold(2'b10, 1'b1, 10);
    hold(2'b11, 1'b1, 12);
    // Reset while KEY[1] is mid-hold, key still down through release.
    hold(2'b10, 1'b1, 10);
    hold(2'b11, 1'b1, 10);
    hold(2'b01, 1'b1, 12);
    hold(2'b01, 1'b0, 3);
    hold(2'b01, 1'b1, 2);
    hold(2'b11, 1'b1, 20);
    // Randomised segments with occasional resets.
    for (int s = 0; s < 300; s++) begin
      rk = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) hold(rk, 1'b0, int'($urandom_range(1, 3)));
      else                            hold(rk, 1'b1, int'($urandom_range(1, 30)));
    end
    hold(2'b11, 1'b1, 40);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected events, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_mode_controller.md
Name: key_mode_controller

Overview:
- Sequential input-side controller for the DE10-Lite calculator. It is the read end of the key-to-display path, feeding the display multiplexer's mode select.
- Synchronises and debounces the two raw active-low KEY buttons, turns them into clean press/release events, and runs a mode state machine.
- Drives the 2-bit MODE select: 0 arithmetic, 1 logical, 2 comparison, 3 magic. Replaces the purely combinational key-to-MODE mapping.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised key level must stay unchanged before it is accepted (10 ms at 50 MHz).
- HOLD_CYCLES, 50000000, cycles KEY[1] must stay debounced-pressed to count as a long press (1 s at 50 MHz).

Ports:
- CLK  in  1  system clock (50 MHz board clock).
- RESET_N  in  1  synchronous, active-low reset.
- KEY  in  2  raw push buttons, active-low (0 = pressed), asynchronous to CLK.
- MODE  out  2  current mode select to the display multiplexer.
- KEY_PRESS  out  2  one-cycle pulse per key on each debounced press edge.
- MODE_CHANGED  out  1  one-cycle pulse on the cycle MODE takes a new value.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: sampled only on the CLK rising edge while RESET_N = 0.
- Reset values:
  - MODE = 0, KEY_PRESS = 0, MODE_CHANGED = 0.
  - Synchroniser flops and debounced levels = 1 (released); debounce and hold counters = 0; KEY[1] FSM = RELEASED.
  - Reset mid-debounce or mid-hold discards all progress.
  - A key physically held through reset release is only seen as pressed after a full debounce; no press pulse is generated at reset release itself.
- Synchroniser: 2-flop synchroniser per key bit.
- Debounce, per key:
  - If the synchronised level differs from the debounced level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves the debounced level unchanged.
- KEY_PRESS[i]: asserted for exactly 1 cycle, registered, on a 1 -> 0 transition of the debounced level.
  - Latency from a clean raw falling edge to the KEY_PRESS pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- KEY[0] action: a press increments MODE modulo 4 (3 wraps to 0).
- KEY[1] FSM states and transitions:
  - RELEASED: on a debounced press, go to PRESSED and clear the hold counter.
  - PRESSED: the hold counter increments each cycle.
    - Debounced release before the count reaches HOLD_CYCLES-1: short press. MODE decrements modulo 4 (0 wraps to 3). Return to RELEASED.
    - Count reaches HOLD_CYCLES-1 while still pressed: long press. MODE := 0. Go to HELD.
  - HELD: wait for debounced release, then go to RELEASED with no MODE action.
  - The hold counter saturates; it never wraps.
- MODE update: MODE is registered and updates on the edge after the triggering event.
  - MODE_CHANGED pulses in the same cycle the new MODE value first appears, and only if the value differs from the old one.
  - A long press while MODE is already 0 gives no MODE_CHANGED.
- Simultaneous events in the same cycle:
  - Long-press reset overrides a KEY[0] increment: MODE = 0.
  - KEY[0] increment and KEY[1] short-press decrement cancel: MODE unchanged, no MODE_CHANGED.
  - KEY_PRESS pulses for both keys are still emitted independently.
- Both keys held together: each is handled independently per the rules above.

Decomposition:
- Shared package holds:
  - Mode encodings MODE_ARITH = 2'd0, MODE_LOGIC = 2'd1, MODE_COMPARE = 2'd2, MODE_MAGIC = 2'd3.
  - KEY[1] FSM state typedef: RELEASED, PRESSED, HELD.
- Natural sub-module: key_debouncer, one instance per key.
  - Contains the synchroniser, debounce counter, debounced level and press-edge pulse.
  - Parameterised by DEBOUNCE_CYCLES.
- The MODE logic and the KEY[1] FSM stay in the top of this block.

Test Plan (bench uses DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 16):
- Reset, then hold KEY = 2'b11 for 50 cycles -> MODE = 0; KEY_PRESS and MODE_CHANGED never assert.
- KEY[0] driven low cleanly at cycle t -> KEY_PRESS[0] pulses at t+7. MODE goes 0 -> 1 at t+8 with MODE_CHANGED. Repeat 4 presses total -> MODE sequence 1, 2, 3, 0.
- KEY[0] bounces 0/1 every 2 cycles for 20 cycles, then stays high -> no KEY_PRESS, MODE unchanged.
- From MODE = 0, KEY[1] pressed for 8 debounced cycles then released -> MODE = 3 after the release debounce, MODE_CHANGED pulses once.
- From MODE = 2, KEY[1] held 40 cycles -> MODE = 0 exactly 16 cycles after KEY_PRESS[1]; the later release gives no change.
- KEY[0] press and KEY[1] short-press release aligned to the same cycle -> MODE unchanged, no MODE_CHANGED. Separately, assert RESET_N = 0 mid-hold -> MODE = 0, FSM = RELEASED, and no spurious pulse after reset.
